// File: rtl/ahb_to_axi3_bridge_pkg.sv
// Shared types and encodings for the AHB-to-AXI3 single-outstanding bridge.
package ahb_to_axi3_bridge_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_WDAT, S_WREQ, S_WRSP, S_RREQ, S_RDAT, S_ERR1, S_ERR2
  } bridge_state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

endpackage

// File: rtl/ahb_to_axi3_bridge_if.sv
// AHB slave-side and AXI3 master-side bundle; slave = bridge view, master = environment view.
interface ahb_to_axi3_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 2
);
  logic              hsel;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [2:0]        hburst;
  logic [3:0]        hprot;
  logic [ADDR_W-1:0] haddr;
  logic [DATA_W-1:0] hwdata;
  logic              hready;
  logic              hreadyout;
  logic [1:0]        hresp;
  logic [DATA_W-1:0] hrdata;

  logic [ID_W-1:0]   awid;
  logic [ADDR_W-1:0] awaddr;
  logic [3:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic [1:0]        awlock;
  logic [3:0]        awcache;
  logic [2:0]        awprot;
  logic              awvalid;
  logic              awready;

  logic [ID_W-1:0]     wid;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;

  logic [ID_W-1:0]   bid;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [3:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic [1:0]        arlock;
  logic [3:0]        arcache;
  logic [2:0]        arprot;
  logic              arvalid;
  logic              arready;

  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport slave (
    input  hsel, htrans, hwrite, hsize, hburst, hprot, haddr, hwdata, hready,
    output hreadyout, hresp, hrdata,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport master (
    output hsel, htrans, hwrite, hsize, hburst, hprot, haddr, hwdata, hready,
    input  hreadyout, hresp, hrdata,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/ahb_axi3_wstrb_gen.sv
// Byte-lane strobe for one AHB beat plus detection of sizes wider than the bus.
module ahb_axi3_wstrb_gen #(
  parameter int DATA_W = 32
) (
  input  logic [2:0]                  hsize,
  input  logic [$clog2(DATA_W/8)-1:0] addr_lo,
  output logic [DATA_W/8-1:0]         strb,
  output logic                        size_err
);
  localparam int BYTES    = DATA_W / 8;
  localparam int MAX_SIZE = $clog2(BYTES);

  int nb;
  int off;

  // Lanes [off, off+nb) are enabled; anything shifted past the top lane is dropped.
  always_comb begin
    nb       = 1 << hsize;
    off      = int'(addr_lo);
    size_err = (int'(hsize) > MAX_SIZE);
    strb     = '0;
    for (int i = 0; i < BYTES; i++)
      strb[i] = (i >= off) && (i < off + nb);
  end
endmodule

// File: rtl/ahb_to_axi3_bridge.sv
// AHB slave to AXI3 master: one single-beat AXI transaction per AHB transfer, data phase stalled until done.
module ahb_to_axi3_bridge
  import ahb_to_axi3_bridge_pkg::*;
#(
  parameter int AHB_ADDRESS_WIDTH = 32,
  parameter int AHB_DATA_WIDTH    = 32,
  parameter int AXI_ID_WIDTH      = 2,
  parameter int AXI_ID            = 0
) (
  input logic                 hclk,
  input logic                 hresetn,
  ahb_to_axi3_bridge_if.slave bus
);
  localparam int OFF_W = $clog2(AHB_DATA_WIDTH / 8);
  localparam logic [AXI_ID_WIDTH-1:0] ID_C = AXI_ID_WIDTH'(AXI_ID);

  bridge_state_e               state;
  logic [AHB_ADDRESS_WIDTH-1:0] haddr_c;
  logic [AHB_DATA_WIDTH/8-1:0]  strb;
  logic                         size_err;
  logic                         accept;
  logic [3:0]                   cache;
  logic [2:0]                   prot;

  assign haddr_c = bus.haddr;
  assign accept  = bus.hsel && bus.hready &&
                   (bus.htrans == HTRANS_NONSEQ || bus.htrans == HTRANS_SEQ);
  assign cache   = {2'b00, bus.hprot[3], bus.hprot[2]};
  assign prot    = {~bus.hprot[0], 1'b0, bus.hprot[1]};

  ahb_axi3_wstrb_gen #(.DATA_W(AHB_DATA_WIDTH)) u_wstrb (
    .hsize    (bus.hsize),
    .addr_lo  (bus.haddr[OFF_W-1:0]),
    .strb     (strb),
    .size_err (size_err)
  );

  assign bus.awlen   = 4'd0;
  assign bus.awburst = AXI_BURST_INCR;
  assign bus.awlock  = 2'b00;
  assign bus.arlen   = 4'd0;
  assign bus.arburst = AXI_BURST_INCR;
  assign bus.arlock  = 2'b00;
  assign bus.wlast   = 1'b1;

  // IDs, response LSBs (EXOKAY == OKAY) and rlast carry nothing the bridge acts on.
  logic unused_in;
  assign unused_in = ^{bus.hburst, bus.bid, bus.rid, bus.rlast, bus.bresp[0], bus.rresp[0]};

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state         <= S_IDLE;
      bus.hreadyout <= 1'b1;
      bus.hresp     <= HRESP_OKAY;
      bus.hrdata    <= '0;
      bus.awvalid   <= 1'b0;
      bus.wvalid    <= 1'b0;
      bus.arvalid   <= 1'b0;
      bus.bready    <= 1'b0;
      bus.rready    <= 1'b0;
      bus.awid      <= '0;
      bus.wid       <= '0;
      bus.arid      <= '0;
      bus.awaddr    <= '0;
      bus.araddr    <= '0;
      bus.awsize    <= '0;
      bus.arsize    <= '0;
      bus.awcache   <= '0;
      bus.arcache   <= '0;
      bus.awprot    <= '0;
      bus.arprot    <= '0;
      bus.wdata     <= '0;
      bus.wstrb     <= '0;
    end else begin
      case (state)
        // ERR2 is the second (ready) cycle of ERROR, so it may start the next transfer.
        S_IDLE, S_ERR2: begin
          state         <= S_IDLE;
          bus.hresp     <= HRESP_OKAY;
          bus.hreadyout <= 1'b1;
          if (accept) begin
            bus.hreadyout <= 1'b0;
            if (size_err) begin
              state     <= S_ERR1;
              bus.hresp <= HRESP_ERROR;
            end else if (bus.hwrite) begin
              state       <= S_WDAT;
              bus.awid    <= ID_C;
              bus.wid     <= ID_C;
              bus.awaddr  <= haddr_c;
              bus.awsize  <= bus.hsize;
              bus.awcache <= cache;
              bus.awprot  <= prot;
              bus.wstrb   <= strb;
            end else begin
              state       <= S_RREQ;
              bus.arid    <= ID_C;
              bus.araddr  <= haddr_c;
              bus.arsize  <= bus.hsize;
              bus.arcache <= cache;
              bus.arprot  <= prot;
              bus.arvalid <= 1'b1;
            end
          end
        end
        S_WDAT: begin
          state       <= S_WREQ;
          bus.wdata   <= bus.hwdata;
          bus.awvalid <= 1'b1;
          bus.wvalid  <= 1'b1;
        end
        S_WREQ: begin
          if (bus.awready) bus.awvalid <= 1'b0;
          if (bus.wready)  bus.wvalid  <= 1'b0;
          if ((!bus.awvalid || bus.awready) && (!bus.wvalid || bus.wready)) begin
            state      <= S_WRSP;
            bus.bready <= 1'b1;
          end
        end
        S_WRSP: begin
          if (bus.bvalid) begin
            bus.bready <= 1'b0;
            if (bus.bresp[1]) begin
              state     <= S_ERR1;
              bus.hresp <= HRESP_ERROR;
            end else begin
              state         <= S_IDLE;
              bus.hreadyout <= 1'b1;
            end
          end
        end
        S_RREQ: begin
          if (bus.arready) begin
            state       <= S_RDAT;
            bus.arvalid <= 1'b0;
            bus.rready  <= 1'b1;
          end
        end
        S_RDAT: begin
          if (bus.rvalid) begin
            bus.rready <= 1'b0;
            bus.hrdata <= bus.rdata;
            if (bus.rresp[1]) begin
              state     <= S_ERR1;
              bus.hresp <= HRESP_ERROR;
            end else begin
              state         <= S_IDLE;
              bus.hreadyout <= 1'b1;
            end
          end
        end
        S_ERR1: begin
          state         <= S_ERR2;
          bus.hreadyout <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
